tdm_demux_8ch: RTL

//  Time-division demultiplexer, the receive-side counterpart of the 8:1 MUX: takes one serial bit per

---
 rtl/tdm_demux_8ch.sv | 113 +++++++++++
 1 files changed

// File: rtl/tdm_demux_8ch.sv
// Receive-side TDM demultiplexer: routes one serial bit per enabled cycle to a slot aligned by
// frame_sync, and reassembles complete frames in slot order.
module tdm_demux_8ch #(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned SEL_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             din_i,
    input  logic             din_en_i,
    input  logic             frame_sync_i,
    output logic [N_CH-1:0]  ch_out_o,
    output logic [SEL_W-1:0] ch_sel_o,
    output logic             ch_valid_o,
    output logic [N_CH-1:0]  frame_out_o,
    output logic             frame_valid_o,
    output logic             locked_o,
    output logic             sync_err_o
);

    localparam logic [0:0] StHunt = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    localparam logic [SEL_W-1:0] LastSlot = SEL_W'(N_CH - 1);

    logic [0:0]       state_q, state_d;
    logic [SEL_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0]  asm_q, asm_d;
    logic [N_CH-1:0]  ch_out_q, ch_out_d;
    logic [SEL_W-1:0] ch_sel_q, ch_sel_d;
    logic             ch_valid_q, ch_valid_d;
    logic [N_CH-1:0]  frame_out_q, frame_out_d;
    logic             frame_valid_q, frame_valid_d;
    logic             sync_err_q, sync_err_d;

    logic             accept;
    logic             realign;
    logic [SEL_W-1:0] slot;
    logic             frame_done;

    always_comb begin
        accept     = din_en_i & ((state_q == StRun) | frame_sync_i);
        // Any accepted frame_sync forces slot 0, whether it is the first lock or a resync.
        realign    = accept & frame_sync_i;
        slot       = realign ? '0 : cnt_q;
        frame_done = accept & (slot == LastSlot);
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        asm_d         = asm_q;
        ch_out_d      = ch_out_q;
        ch_sel_d      = ch_sel_q;
        ch_valid_d    = 1'b0;
        frame_out_d   = frame_out_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (accept) begin
            state_d    = StRun;
            cnt_d      = slot + SEL_W'(1);
            ch_out_d   = N_CH'(din_i) << slot;
            ch_sel_d   = slot;
            ch_valid_d = 1'b1;
            sync_err_d = frame_sync_i & (state_q == StRun) & (cnt_q != '0);

            // Clearing on slot 0 keeps a discarded partial frame out of the next one.
            if (slot == '0) begin
                asm_d = '0;
            end
            asm_d[slot] = din_i;

            if (frame_done) begin
                frame_out_d   = {din_i, asm_q[N_CH-2:0]};
                frame_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StHunt;
            cnt_q         <= '0;
            asm_q         <= '0;
            ch_out_q      <= '0;
            ch_sel_q      <= '0;
            ch_valid_q    <= 1'b0;
            frame_out_q   <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            asm_q         <= asm_d;
            ch_out_q      <= ch_out_d;
            ch_sel_q      <= ch_sel_d;
            ch_valid_q    <= ch_valid_d;
            frame_out_q   <= frame_out_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign ch_out_o      = ch_out_q;
    assign ch_sel_o      = ch_sel_q;
    assign ch_valid_o    = ch_valid_q;
    assign frame_out_o   = frame_out_q;
    assign frame_valid_o = frame_valid_q;
    assign locked_o      = (state_q == StRun);
    assign sync_err_o    = sync_err_q;

endmodule
